// File: rtl/mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared types and constants for the sequential 24x24 multiplier.
//   - state_e : controller states (IDLE, RUN, DONE)
//   - pass_e  : partial-product pass encoding. Bit 1 selects the a-half and
//               bit 0 selects the b-half (0 = low, 1 = high).
//   - W/H/PW  : operand, half and product widths
//   - SHIFT_* : left shift applied to each pass's 24-bit partial product
//   - next_pass() : lowest enabled pass at or after a starting index
// -----------------------------------------------------------------------------
package mult_seq_pkg;

    localparam int W  = 24;
    localparam int H  = 12;
    localparam int PW = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PASS_LL = 2'd0,
        PASS_LH = 2'd1,
        PASS_HL = 2'd2,
        PASS_HH = 2'd3
    } pass_e;

    localparam int SHIFT_LL = 0;
    localparam int SHIFT_LH = H;
    localparam int SHIFT_HL = H;
    localparam int SHIFT_HH = 2 * H;

    // Returns {found, index} of the lowest set mask bit whose index is >= from.
    // 'from' is 3 bits wide so that "past the last pass" (4) can be expressed.
    function automatic logic [2:0] next_pass(input logic [3:0] mask,
                                             input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(from)) && mask[i]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult12.sv
// -----------------------------------------------------------------------------
// mult12
// 12x12 unsigned combinational multiplier, shared across the passes of
// mult24_seq.
//   a_i : 12-bit multiplicand
//   b_i : 12-bit multiplier
//   p_o : 24-bit product
// -----------------------------------------------------------------------------
module mult12 (
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    output logic [23:0] p_o
);

    assign p_o = 24'(a_i) * 24'(b_i);

endmodule

// File: rtl/mult24_seq.sv
// -----------------------------------------------------------------------------
// mult24_seq
// Sequential 24x24 unsigned multiplier. A single 12x12 multiplier is
// time-multiplexed over up to four partial-product passes (LL, LH, HL, HH),
// and the results are accumulated into a 48-bit register. Only one job is in
// flight at a time.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand pair valid
//   in_ready  : operands accepted this cycle (IDLE, or DONE with out_ready)
//   a, b      : 24-bit unsigned operands, sampled only at acceptance
//   out_valid : product valid, held until accepted
//   out_ready : consumer accepts the product
//   p         : 48-bit product, driven directly by the accumulator register
//
// Build option
//   MULT_SEQ_SKIP_EN : when defined, passes whose a-half or b-half is zero
//                      are skipped. LL always runs if every pass would be
//                      skipped. The product is the same in both builds.
// -----------------------------------------------------------------------------
module mult24_seq
    import mult_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] p
);

    state_e        state_q, state_d;
    pass_e         pass_q,  pass_d;
    logic [3:0]    mask_q,  mask_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic [PW-1:0] acc_q,   acc_d;

    logic [H-1:0]  mul_a, mul_b;
    logic [2*H-1:0] pp;
    logic [PW-1:0] pp_sh;
    logic [3:0]    accept_mask;
    logic [2:0]    first_sel;
    logic [2:0]    next_sel;
    logic          accept;

    // Operand-half muxes are steered by the pass encoding bits.
    assign mul_a = pass_q[1] ? a_q[W-1:H] : a_q[H-1:0];
    assign mul_b = pass_q[0] ? b_q[W-1:H] : b_q[H-1:0];

    mult12 u_mult12 (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (pp)
    );

    always_comb begin
        pp_sh = '0;
        case (pass_q)
            PASS_LL: pp_sh = PW'(pp) << SHIFT_LL;
            PASS_LH: pp_sh = PW'(pp) << SHIFT_LH;
            PASS_HL: pp_sh = PW'(pp) << SHIFT_HL;
            PASS_HH: pp_sh = PW'(pp) << SHIFT_HH;
            default: pp_sh = '0;
        endcase
    end

    // The pass mask is computed from the live inputs, because it is only used
    // on the acceptance cycle. Bit index equals the pass encoding.
`ifdef MULT_SEQ_SKIP_EN
    always_comb begin
        accept_mask[PASS_LL] = (a[H-1:0] != '0) && (b[H-1:0] != '0);
        accept_mask[PASS_LH] = (a[H-1:0] != '0) && (b[W-1:H] != '0);
        accept_mask[PASS_HL] = (a[W-1:H] != '0) && (b[H-1:0] != '0);
        accept_mask[PASS_HH] = (a[W-1:H] != '0) && (b[W-1:H] != '0);
        // A zero operand still needs one pass to deliver the (zero) result.
        if (accept_mask == 4'b0000) begin
            accept_mask = 4'b0001;
        end
    end
`else
    assign accept_mask = 4'b1111;
`endif

    assign first_sel = next_pass(accept_mask, 3'd0);
    assign next_sel  = next_pass(mask_q, {1'b0, pass_q} + 3'd1);

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign p         = acc_q;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        mask_d  = mask_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;

        case (state_q)
            RUN: begin
                acc_d = acc_q + pp_sh;
                if (next_sel[2]) begin
                    pass_d = pass_e'(next_sel[1:0]);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Acceptance covers both IDLE and the DONE->RUN handoff.
        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            mask_d  = accept_mask;
            pass_d  = pass_e'(first_sel[1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= PASS_LL;
            mask_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_mult24_seq.sv
// -----------------------------------------------------------------------------
// tb_mult24_seq
// Self-checking bench for mult24_seq: directed corner cases plus randomized
// jobs. Each job is checked against plain a*b arithmetic, and its latency
// against the pass-count rule.
// -----------------------------------------------------------------------------
module tb_mult24_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] p;

    int n_checks = 0;
    int n_fail   = 0;

    mult24_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] ref_prod(input logic [23:0] x, input logic [23:0] y);
        return 48'(x) * 48'(y);
    endfunction

    function automatic int ref_lat(input logic [23:0] x, input logic [23:0] y);
`ifdef MULT_SEQ_SKIP_EN
        int n;
        n = 0;
        if (x[11:0]  != 0 && y[11:0]  != 0) n++;
        if (x[11:0]  != 0 && y[23:12] != 0) n++;
        if (x[23:12] != 0 && y[11:0]  != 0) n++;
        if (x[23:12] != 0 && y[23:12] != 0) n++;
        return (n == 0) ? 1 : n;
`else
        return 4;
`endif
    endfunction

    // Counts edges after acceptance until out_valid rises (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_job(input logic [23:0] x, input logic [23:0] y,
                           input bit consume, input int hold);
        int w;
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 24'($urandom);
        b        = 24'($urandom);
        wait_done(lat);
        check("latency", 64'(lat), 64'(ref_lat(x, y)));
        check("product", 64'(p), 64'(ref_prod(x, y)));
        check("in_ready_in_done", 64'(in_ready), 64'd0);
        if (consume) begin
            repeat (hold) @(negedge clk);
            check("held_product", 64'(p), 64'(ref_prod(x, y)));
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check("consumed", 64'(out_valid), 64'd0);
        end
    endtask

    function automatic logic [11:0] rand_half();
        return ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    endfunction

    initial begin
        int  lat;
        bit  seen;
        logic [23:0] ra, rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p",         64'(p),         64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_in_ready",  64'(in_ready),  64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_p",         64'(p),         64'd0);

        run_job(24'hFFFFFF, 24'hFFFFFF, 1'b1, 0);
        check("max_product_const", 64'(p), 64'h0000_FFFF_FE00_0001);
        run_job(24'd3, 24'd5, 1'b1, 1);
        run_job(24'h001000, 24'h000FFF, 1'b1, 0);
        run_job(24'd0, 24'hABCDEF, 1'b1, 0);

        // Backpressure followed by a same-cycle consume and new accept.
        run_job(24'd7, 24'd9, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_p",         64'(p),         64'd63);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 24'd2;
        b         = 24'd4;
        #1;
        check("handoff_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("handoff_running", 64'(out_valid), 64'd0);
        wait_done(lat);
        check("handoff_latency", 64'(lat), 64'(ref_lat(24'd2, 24'd4)));
        check("handoff_p",       64'(p),   64'd8);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second pass discards the job.
        in_valid = 1'b1;
        a        = 24'h123456;
        b        = 24'h654321;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_p",         64'(p),         64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        run_job(24'd10, 24'd10, 1'b1, 0);

        // Randomized jobs with zero halves biased in.
        for (int j = 0; j < 40; j++) begin
            ra = {rand_half(), rand_half()};
            rb = {rand_half(), rand_half()};
            run_job(ra, rb, 1'b1, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
